// File: rtl/host_rd_arbiter_if.sv
// AR/R bundle shared by the two kernel read masters and the host read port.
// The master modport is the arbiter's view; slave is the surrounding fabric.
interface host_rd_arbiter_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 512,
  parameter int LEN_WIDTH  = 8
);
  logic                  s0_arvalid, s1_arvalid;
  logic                  s0_arready, s1_arready;
  logic [ADDR_WIDTH-1:0] s0_araddr,  s1_araddr;
  logic [LEN_WIDTH-1:0]  s0_arlen,   s1_arlen;
  logic [2:0]            s0_arsize,  s1_arsize;
  logic                  s0_rvalid,  s1_rvalid;
  logic                  s0_rready,  s1_rready;
  logic [DATA_WIDTH-1:0] s0_rdata,   s1_rdata;
  logic [1:0]            s0_rresp,   s1_rresp;
  logic                  s0_rlast,   s1_rlast;

  logic                  m_arvalid;
  logic                  m_arready;
  logic [ADDR_WIDTH-1:0] m_araddr;
  logic [LEN_WIDTH-1:0]  m_arlen;
  logic [2:0]            m_arsize;
  logic                  m_rvalid;
  logic                  m_rready;
  logic [DATA_WIDTH-1:0] m_rdata;
  logic [1:0]            m_rresp;
  logic                  m_rlast;

  modport master (
    input  s0_arvalid, s1_arvalid, s0_araddr, s1_araddr,
           s0_arlen, s1_arlen, s0_arsize, s1_arsize, s0_rready, s1_rready,
           m_arready, m_rvalid, m_rdata, m_rresp, m_rlast,
    output s0_arready, s1_arready, s0_rvalid, s1_rvalid,
           s0_rdata, s1_rdata, s0_rresp, s1_rresp, s0_rlast, s1_rlast,
           m_arvalid, m_araddr, m_arlen, m_arsize, m_rready
  );

  modport slave (
    output s0_arvalid, s1_arvalid, s0_araddr, s1_araddr,
           s0_arlen, s1_arlen, s0_arsize, s1_arsize, s0_rready, s1_rready,
           m_arready, m_rvalid, m_rdata, m_rresp, m_rlast,
    input  s0_arready, s1_arready, s0_rvalid, s1_rvalid,
           s0_rdata, s1_rdata, s0_rresp, s1_rresp, s0_rlast, s1_rlast,
           m_arvalid, m_araddr, m_arlen, m_arsize, m_rready
  );
endinterface

// File: rtl/host_rd_arbiter.sv
// Two-to-one AXI4 read arbiter onto a single in-order, fixed-ID host read port.
// R beats are steered by a FIFO recording which requester owns each accepted burst.
module host_rd_arbiter #(
  parameter int ADDR_WIDTH      = 64,
  parameter int DATA_WIDTH      = 512,
  parameter int LEN_WIDTH       = 8,
  parameter int MAX_OUTSTANDING = 16
) (
  input  logic                               clk,
  input  logic                               reset_n,
  host_rd_arbiter_if.master                  bus,
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding
);

  localparam int PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {ST_IDLE, ST_HOLD} state_t;

  state_t                 state_q, state_d;
  logic                   rr_q, rr_d;
  logic [ADDR_WIDTH-1:0]  araddr_q, araddr_d;
  logic [LEN_WIDTH-1:0]   arlen_q, arlen_d;
  logic [2:0]             arsize_q, arsize_d;

  logic [MAX_OUTSTANDING-1:0] fifo_q;
  logic [PTR_W-1:0]           wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]           count_q, count_d;

  logic push, pop, grant_sel, can_grant, fifo_empty, head;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      rr_q     <= 1'b0;
      araddr_q <= '0;
      arlen_q  <= '0;
      arsize_q <= '0;
      fifo_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      araddr_q <= araddr_d;
      arlen_q  <= arlen_d;
      arsize_q <= arsize_d;
      count_q  <= count_d;
      if (push) begin
        fifo_q[wr_ptr_q] <= grant_sel;
        wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  // reset_n gates the grant so arready reads 0 while reset is held, not just after it
  assign can_grant = reset_n && (count_q != CNT_W'(MAX_OUTSTANDING));

  always_comb begin
    state_d        = state_q;
    rr_d           = rr_q;
    araddr_d       = araddr_q;
    arlen_d        = arlen_q;
    arsize_d       = arsize_q;
    push           = 1'b0;
    grant_sel      = 1'b0;
    bus.s0_arready = 1'b0;
    bus.s1_arready = 1'b0;
    bus.m_arvalid  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (can_grant && (bus.s0_arvalid || bus.s1_arvalid)) begin
          if (rr_q) grant_sel = bus.s1_arvalid ? 1'b1 : 1'b0;
          else      grant_sel = bus.s0_arvalid ? 1'b0 : 1'b1;
          if (grant_sel) begin
            bus.s1_arready = 1'b1;
            araddr_d       = bus.s1_araddr;
            arlen_d        = bus.s1_arlen;
            arsize_d       = bus.s1_arsize;
          end else begin
            bus.s0_arready = 1'b1;
            araddr_d       = bus.s0_araddr;
            arlen_d        = bus.s0_arlen;
            arsize_d       = bus.s0_arsize;
          end
          push    = 1'b1;
          rr_d    = ~grant_sel;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        bus.m_arvalid = 1'b1;
        if (bus.m_arready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.m_araddr = araddr_q;
  assign bus.m_arlen  = arlen_q;
  assign bus.m_arsize = arsize_q;

  assign fifo_empty = (count_q == '0);
  assign head       = fifo_q[rd_ptr_q];

  always_comb begin
    bus.s0_rvalid = 1'b0;
    bus.s1_rvalid = 1'b0;
    bus.m_rready  = 1'b0;
    if (!fifo_empty) begin
      if (head) begin
        bus.s1_rvalid = bus.m_rvalid;
        bus.m_rready  = bus.s1_rready;
      end else begin
        bus.s0_rvalid = bus.m_rvalid;
        bus.m_rready  = bus.s0_rready;
      end
    end
  end

  assign pop = bus.m_rvalid && bus.m_rready && bus.m_rlast;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  assign outstanding  = count_q;
  assign bus.s0_rdata = bus.m_rdata;
  assign bus.s1_rdata = bus.m_rdata;
  assign bus.s0_rresp = bus.m_rresp;
  assign bus.s1_rresp = bus.m_rresp;
  assign bus.s0_rlast = bus.m_rlast;
  assign bus.s1_rlast = bus.m_rlast;

  // Host returning data with nothing outstanding is a host protocol error
  a_no_orphan_r: assert property (@(posedge clk) disable iff (!reset_n)
                                  !(bus.m_rvalid && fifo_empty));

endmodule

// File: tb/tb_host_rd_arbiter.sv
// Bench for host_rd_arbiter: directed scenarios plus a randomized run checked
// against a queue-based model of grant order and burst ownership.
module tb_host_rd_arbiter;

  localparam int MAXO = 16;

  logic       clk;
  logic       reset_n;
  logic [4:0] outstanding;
  int         vectors;
  int         miscompares;

  host_rd_arbiter_if #(.ADDR_WIDTH(64), .DATA_WIDTH(512), .LEN_WIDTH(8)) bus ();

  host_rd_arbiter #(
    .ADDR_WIDTH(64), .DATA_WIDTH(512), .LEN_WIDTH(8), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus), .outstanding(outstanding)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.s0_arvalid = 0; bus.s1_arvalid = 0;
    bus.s0_araddr = '0; bus.s1_araddr = '0;
    bus.s0_arlen = '0;  bus.s1_arlen = '0;
    bus.s0_arsize = '0; bus.s1_arsize = '0;
    bus.s0_rready = 0;  bus.s1_rready = 0;
    bus.m_arready = 0;  bus.m_rvalid = 0;
    bus.m_rdata = '0;   bus.m_rresp = '0; bus.m_rlast = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
  endtask

  task automatic test_reset();
    do_reset();
    tick();
    reset_n = 0;
    bus.s0_arvalid = 1; bus.s1_arvalid = 1;
    #1;
    vectors++;
    if ({bus.m_arvalid, bus.s0_arready, bus.s1_arready, bus.s0_rvalid, bus.s1_rvalid, bus.m_rready} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl got %b want 000000", {bus.m_arvalid, bus.s0_arready, bus.s1_arready, bus.s0_rvalid, bus.s1_rvalid, bus.m_rready});
    end
    vectors++;
    if ({bus.m_araddr, bus.m_arlen, bus.m_arsize} !== 75'd0 || outstanding !== 5'd0) begin
      miscompares++;
      $display("FAIL reset_fields got addr=%h len=%h size=%h out=%0d want all 0", bus.m_araddr, bus.m_arlen, bus.m_arsize, outstanding);
    end
    idle_inputs();
    #1 reset_n = 1;
  endtask

  task automatic test_single_burst();
    do_reset();
    bus.s0_arvalid = 1; bus.s0_araddr = 64'h1000; bus.s0_arlen = 8'd3; bus.s0_arsize = 3'd6;
    #1;
    vectors++;
    if ({bus.s0_arready, bus.s1_arready} !== 2'b10) begin
      miscompares++; $display("FAIL single_arready got %b want 10", {bus.s0_arready, bus.s1_arready});
    end
    tick();
    bus.s0_arvalid = 0;
    vectors++;
    if (bus.m_arvalid !== 1'b1 || bus.m_araddr !== 64'h1000 || bus.m_arlen !== 8'd3 || bus.m_arsize !== 3'd6) begin
      miscompares++;
      $display("FAIL single_ar got v=%b addr=%h len=%0d size=%0d want v=1 addr=1000 len=3 size=6", bus.m_arvalid, bus.m_araddr, bus.m_arlen, bus.m_arsize);
    end
    vectors++;
    if (outstanding !== 5'd1) begin
      miscompares++; $display("FAIL single_out1 got %0d want 1", outstanding);
    end
    bus.m_arready = 1;
    tick();
    bus.m_arready = 0;
    vectors++;
    if (bus.m_arvalid !== 1'b0) begin
      miscompares++; $display("FAIL single_ar_drop got %b want 0", bus.m_arvalid);
    end
    bus.s0_rready = 1;
    for (int b = 0; b < 4; b++) begin
      bus.m_rvalid = 1; bus.m_rdata = 512'(32'hA0 + b); bus.m_rlast = (b == 3);
      #1;
      vectors++;
      if ({bus.s0_rvalid, bus.s1_rvalid, bus.m_rready} !== 3'b101 || bus.s0_rdata !== bus.m_rdata) begin
        miscompares++;
        $display("FAIL single_beat%0d got rv0/rv1/mrr=%b data=%h want 101 data=%h", b, {bus.s0_rvalid, bus.s1_rvalid, bus.m_rready}, bus.s0_rdata[31:0], 32'hA0 + b);
      end
      tick();
    end
    bus.m_rvalid = 0; bus.m_rlast = 0;
    vectors++;
    if (outstanding !== 5'd0) begin
      miscompares++; $display("FAIL single_out0 got %0d want 0", outstanding);
    end
  endtask

  task automatic test_contention();
    do_reset();
    bus.s0_arvalid = 1; bus.s1_arvalid = 1; bus.m_arready = 1;
    bus.s0_araddr = 64'h100; bus.s1_araddr = 64'h200;
    for (int i = 0; i < 4; i++) begin
      bus.s0_arlen = 8'(i); bus.s1_arlen = 8'(i);
      #1;
      vectors++;
      if ({bus.s0_arready, bus.s1_arready} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
        miscompares++; $display("FAIL cont_grant%0d got %b want %b", i, {bus.s0_arready, bus.s1_arready}, (i % 2 == 0) ? 2'b10 : 2'b01);
      end
      tick();
      if (i == 3) begin bus.s0_arvalid = 0; bus.s1_arvalid = 0; end
      vectors++;
      if (bus.m_araddr !== ((i % 2 == 0) ? 64'h100 : 64'h200) || bus.m_arlen !== 8'(i) || bus.m_arvalid !== 1'b1) begin
        miscompares++; $display("FAIL cont_ar%0d got addr=%h len=%0d v=%b", i, bus.m_araddr, bus.m_arlen, bus.m_arvalid);
      end
      tick();
    end
    bus.m_arready = 0;
    bus.s0_rready = 1; bus.s1_rready = 1;
    for (int k = 0; k < 4; k++) begin
      for (int b = 0; b <= k; b++) begin
        bus.m_rvalid = 1; bus.m_rlast = (b == k); bus.m_rresp = 2'(k);
        #1;
        vectors++;
        if ({bus.s0_rvalid, bus.s1_rvalid, bus.m_rready} !== ((k % 2 == 0) ? 3'b101 : 3'b011) || bus.s1_rresp !== 2'(k)) begin
          miscompares++; $display("FAIL cont_r%0d_%0d got %b resp=%0d", k, b, {bus.s0_rvalid, bus.s1_rvalid, bus.m_rready}, bus.s1_rresp);
        end
        tick();
      end
      bus.m_rvalid = 0; bus.m_rlast = 0;
      vectors++;
      if (outstanding !== 5'(3 - k)) begin
        miscompares++; $display("FAIL cont_out%0d got %0d want %0d", k, outstanding, 3 - k);
      end
    end
  endtask

  task automatic test_ar_backpressure();
    do_reset();
    bus.s1_arvalid = 1; bus.s1_araddr = 64'hBEEF00; bus.s1_arlen = 8'd7; bus.s1_arsize = 3'd5;
    #1;
    vectors++;
    if ({bus.s0_arready, bus.s1_arready} !== 2'b01) begin
      miscompares++; $display("FAIL bp_grant got %b want 01", {bus.s0_arready, bus.s1_arready});
    end
    tick();
    bus.s0_arvalid = 1; bus.s1_araddr = 64'hDEAD; bus.s1_arlen = 8'd1; bus.s1_arsize = 3'd2;
    for (int c = 0; c < 5; c++) begin
      #1;
      vectors++;
      if ({bus.m_arvalid, bus.s0_arready, bus.s1_arready} !== 3'b100 || bus.m_araddr !== 64'hBEEF00 ||
          bus.m_arlen !== 8'd7 || bus.m_arsize !== 3'd5) begin
        miscompares++;
        $display("FAIL bp_hold%0d got v/r0/r1=%b addr=%h len=%0d size=%0d", c, {bus.m_arvalid, bus.s0_arready, bus.s1_arready}, bus.m_araddr, bus.m_arlen, bus.m_arsize);
      end
      tick();
    end
    bus.m_arready = 1;
    tick();
    vectors++;
    if ({bus.m_arvalid, bus.s0_arready, bus.s1_arready} !== 3'b010) begin
      miscompares++; $display("FAIL bp_release got %b want 010", {bus.m_arvalid, bus.s0_arready, bus.s1_arready});
    end
    bus.s0_arvalid = 0; bus.s1_arvalid = 0;
  endtask

  task automatic test_full();
    do_reset();
    bus.s0_arvalid = 1; bus.s1_arvalid = 1; bus.m_arready = 1;
    for (int i = 0; i < MAXO; i++) begin tick(); tick(); end
    vectors++;
    if (outstanding !== 5'd16 || {bus.s0_arready, bus.s1_arready} !== 2'b00) begin
      miscompares++; $display("FAIL full_16 got out=%0d rdy=%b want 16/00", outstanding, {bus.s0_arready, bus.s1_arready});
    end
    tick();
    vectors++;
    if (outstanding !== 5'd16 || {bus.m_arvalid, bus.s0_arready, bus.s1_arready} !== 3'b000) begin
      miscompares++; $display("FAIL full_stall got out=%0d ctl=%b want 16/000", outstanding, {bus.m_arvalid, bus.s0_arready, bus.s1_arready});
    end
    bus.s0_rready = 1; bus.s1_rready = 1; bus.m_rvalid = 1; bus.m_rlast = 1;
    #1;
    vectors++;
    if ({bus.s0_rvalid, bus.s1_rvalid, bus.m_rready} !== 3'b101) begin
      miscompares++; $display("FAIL full_drain got %b want 101", {bus.s0_rvalid, bus.s1_rvalid, bus.m_rready});
    end
    tick();
    vectors++;
    if (outstanding !== 5'd15 || {bus.s0_arready, bus.s1_arready} !== 2'b10 || {bus.s0_rvalid, bus.s1_rvalid} !== 2'b01) begin
      miscompares++; $display("FAIL full_15 got out=%0d rdy=%b rv=%b want 15/10/01", outstanding, {bus.s0_arready, bus.s1_arready}, {bus.s0_rvalid, bus.s1_rvalid});
    end
    tick();
    bus.m_rvalid = 0; bus.m_rlast = 0;
    vectors++;
    if (outstanding !== 5'd15 || bus.m_arvalid !== 1'b1) begin
      miscompares++; $display("FAIL full_pushpop got out=%0d arv=%b want 15/1", outstanding, bus.m_arvalid);
    end
    tick();
    tick();
    bus.s0_arvalid = 0; bus.s1_arvalid = 0;
    vectors++;
    if (outstanding !== 5'd16) begin
      miscompares++; $display("FAIL full_refill got %0d want 16", outstanding);
    end
  endtask

  task automatic test_r_backpressure();
    logic [2:0] pat;
    do_reset();
    pat = 3'b101;
    bus.s1_arvalid = 1;
    tick();
    bus.s1_arvalid = 0; bus.m_arready = 1;
    tick();
    bus.m_arready = 0; bus.s0_rready = 1; bus.m_rvalid = 1; bus.m_rlast = 0;
    for (int c = 0; c < 3; c++) begin
      bus.s1_rready = pat[2 - c];
      #1;
      vectors++;
      if ({bus.s0_rvalid, bus.s1_rvalid, bus.m_rready} !== {2'b01, pat[2 - c]}) begin
        miscompares++; $display("FAIL rbp%0d got %b want %b", c, {bus.s0_rvalid, bus.s1_rvalid, bus.m_rready}, {2'b01, pat[2 - c]});
      end
      tick();
    end
    bus.m_rvalid = 0;
  endtask

  task automatic test_reset_midop();
    do_reset();
    bus.s0_arvalid = 1; bus.s1_arvalid = 1; bus.m_arready = 1; bus.s0_araddr = 64'h5000;
    repeat (4) tick();
    bus.m_arready = 0;
    tick();
    vectors++;
    if (outstanding !== 5'd3 || bus.m_arvalid !== 1'b1) begin
      miscompares++; $display("FAIL midop_pre got out=%0d arv=%b want 3/1", outstanding, bus.m_arvalid);
    end
    reset_n = 0;
    #1;
    vectors++;
    if ({bus.m_arvalid, bus.s0_arready, bus.s1_arready, bus.m_rready} !== 4'b0 || outstanding !== 5'd0 || bus.m_araddr !== 64'd0) begin
      miscompares++;
      $display("FAIL midop_reset got ctl=%b out=%0d addr=%h want 0", {bus.m_arvalid, bus.s0_arready, bus.s1_arready, bus.m_rready}, outstanding, bus.m_araddr);
    end
    #1 reset_n = 1;
    #1;
    vectors++;
    if ({bus.s0_arready, bus.s1_arready} !== 2'b10 || outstanding !== 5'd0) begin
      miscompares++; $display("FAIL midop_after got rdy=%b out=%0d want 10/0", {bus.s0_arready, bus.s1_arready}, outstanding);
    end
    bus.s0_arvalid = 0; bus.s1_arvalid = 0;
  endtask

  task automatic test_random();
    int           q[$];
    bit           pend;
    logic [74:0]  pfields;
    bit           rr;
    int           g;
    int           h;
    logic [2:0]   exp_r;
    do_reset();
    pend = 0; rr = 0; pfields = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bus.s0_arvalid = ($urandom_range(0, 2) != 0);
      bus.s1_arvalid = ($urandom_range(0, 2) != 0);
      bus.s0_araddr  = {$urandom(), $urandom()};
      bus.s1_araddr  = {$urandom(), $urandom()};
      bus.s0_arlen   = 8'($urandom()); bus.s1_arlen  = 8'($urandom());
      bus.s0_arsize  = 3'($urandom()); bus.s1_arsize = 3'($urandom());
      bus.s0_rready  = ($urandom_range(0, 1) == 1);
      bus.s1_rready  = ($urandom_range(0, 1) == 1);
      bus.m_arready  = ($urandom_range(0, 3) != 0);
      bus.m_rvalid   = (q.size() > 0) && ($urandom_range(0, 1) == 1);
      bus.m_rlast    = ($urandom_range(0, 3) == 0);
      bus.m_rresp    = 2'($urandom());
      for (int w = 0; w < 16; w++) bus.m_rdata[w*32 +: 32] = $urandom();
      #1;
      g = -1;
      if (!pend && (bus.s0_arvalid || bus.s1_arvalid) && q.size() < MAXO)
        g = rr ? (bus.s1_arvalid ? 1 : 0) : (bus.s0_arvalid ? 0 : 1);
      vectors++;
      if ({bus.s0_arready, bus.s1_arready} !== {g == 0, g == 1}) begin
        miscompares++; $display("FAIL rnd_grant cyc%0d got %b want %b", cyc, {bus.s0_arready, bus.s1_arready}, {g == 0, g == 1});
      end
      vectors++;
      if (bus.m_arvalid !== pend || (pend && {bus.m_araddr, bus.m_arlen, bus.m_arsize} !== pfields)) begin
        miscompares++; $display("FAIL rnd_ar cyc%0d got v=%b f=%h want v=%b f=%h", cyc, bus.m_arvalid, {bus.m_araddr, bus.m_arlen, bus.m_arsize}, pend, pfields);
      end
      h = (q.size() > 0) ? q[0] : -1;
      exp_r = {h == 0 && bus.m_rvalid, h == 1 && bus.m_rvalid,
               (h == 0 && bus.s0_rready) || (h == 1 && bus.s1_rready)};
      vectors++;
      if ({bus.s0_rvalid, bus.s1_rvalid, bus.m_rready} !== exp_r || outstanding !== 5'(q.size())) begin
        miscompares++; $display("FAIL rnd_route cyc%0d got %b out=%0d want %b out=%0d", cyc, {bus.s0_rvalid, bus.s1_rvalid, bus.m_rready}, outstanding, exp_r, q.size());
      end
      vectors++;
      if (bus.s0_rdata !== bus.m_rdata || bus.s1_rdata !== bus.m_rdata || bus.s0_rresp !== bus.m_rresp || bus.s1_rlast !== bus.m_rlast) begin
        miscompares++; $display("FAIL rnd_bcast cyc%0d data/resp/last not forwarded", cyc);
      end
      tick();
      if (h >= 0 && bus.m_rvalid && bus.m_rlast && ((h == 0) ? bus.s0_rready : bus.s1_rready))
        void'(q.pop_front());
      if (pend) begin
        if (bus.m_arready) pend = 0;
      end else if (g >= 0) begin
        q.push_back(g);
        pend = 1;
        rr = (g == 0);
        pfields = (g == 0) ? {bus.s0_araddr, bus.s0_arlen, bus.s0_arsize}
                           : {bus.s1_araddr, bus.s1_arlen, bus.s1_arsize};
      end
    end
    idle_inputs();
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset_n = 0;
    idle_inputs();
    test_reset();
    test_single_burst();
    test_contention();
    test_ar_backpressure();
    test_full();
    test_r_backpressure();
    test_reset_midop();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
